// File: rtl/seq_stim_pkg.sv
// rtl/seq_stim_pkg.sv - phase encoding, run-state helper and default trace lengths
package seq_stim_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN0     = 3'd1,
      CLR_BOTH = 3'd2,
      RUN1     = 3'd3,
      CLR_R2   = 3'd4,
      RUN2     = 3'd5,
      DONE     = 3'd6
   } phase_t;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_RUN0_CYCLES = 15;
   localparam int DEF_RUN1_CYCLES = 5;
   localparam int DEF_RUN2_CYCLES = 5;
   localparam int DEF_VCNT_WIDTH  = 16;

   function automatic logic is_run(input phase_t p);
      return (p == RUN0) || (p == RUN1) || (p == RUN2);
   endfunction

endpackage

// File: rtl/seq_stim_gen_satcnt.sv
// rtl/seq_stim_gen_satcnt.sv - saturating up-counter with synchronous clear
module seq_stim_satcnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_stim_gen.sv
// rtl/seq_stim_gen.sv - scripted r1/r2 counter trace with golden violation count
module seq_stim_gen
   import seq_stim_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int RUN0_CYCLES = DEF_RUN0_CYCLES,
   parameter int RUN1_CYCLES = DEF_RUN1_CYCLES,
   parameter int RUN2_CYCLES = DEF_RUN2_CYCLES,
   parameter int VCNT_WIDTH  = DEF_VCNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  step_en,
   output logic [WIDTH-1:0]      r1_o,
   output logic [WIDTH-1:0]      r2_o,
   output logic [2:0]            phase_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  viol_o,
   output logic [VCNT_WIDTH-1:0] viol_cnt_o
);

   phase_t           state_q, state_d;
   logic [WIDTH-1:0] r1_q, r1_d;
   logic [WIDTH-1:0] r2_q, r2_d;
   logic [31:0]      step_q, step_d;
   logic [31:0]      step_inc;
   logic [31:0]      run_len;
   logic             viol;
   logic             vclr;

   assign viol     = is_run(state_q) && step_en && !(r1_q < r2_q);
   assign step_inc = step_q + 32'd1;

   always_comb begin
      state_d = state_q;
      r1_d    = r1_q;
      r2_d    = r2_q;
      step_d  = step_q;
      vclr    = 1'b0;
      run_len = 32'(RUN2_CYCLES);

      case (state_q)
         RUN0:    run_len = 32'(RUN0_CYCLES);
         RUN1:    run_len = 32'(RUN1_CYCLES);
         default: run_len = 32'(RUN2_CYCLES);
      endcase

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN0;
               r1_d    = '0;
               r2_d    = '0;
               step_d  = '0;
               vclr    = 1'b1;
            end
         end
         CLR_BOTH: state_d = RUN1;
         CLR_R2:   state_d = RUN2;
         RUN0, RUN1, RUN2: begin
            if (step_en) begin
               r1_d   = r1_q + WIDTH'(1);
               r2_d   = r2_q + WIDTH'(2);
               step_d = step_inc;
               // The final step's increment lands; the clear of the next phase overrides it.
               if (step_inc == run_len) begin
                  step_d = '0;
                  case (state_q)
                     RUN0: begin
                        state_d = CLR_BOTH;
                        r1_d    = '0;
                        r2_d    = '0;
                     end
                     RUN1: begin
                        state_d = CLR_R2;
                        r2_d    = '0;
                     end
                     default: state_d = DONE;
                  endcase
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r1_q    <= '0;
         r2_q    <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
         step_q  <= step_d;
      end
   end

   seq_stim_satcnt #(
      .W(VCNT_WIDTH)
   ) u_viol_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (viol),
      .clr   (vclr),
      .cnt_o (viol_cnt_o)
   );

   assign r1_o    = r1_q;
   assign r2_o    = r2_q;
   assign phase_o = state_q;
   assign busy_o  = (state_q != IDLE) && (state_q != DONE);
   assign done_o  = (state_q == DONE);
   assign viol_o  = viol;

endmodule
